// File: rtl/csi2_raw10_unpacker.sv
// CSI-2 RAW10 byte-to-pixel unpacker: turns registered long-packet payload bytes into 10-bit
// pixels with line/frame framing, per-line/per-frame counts and sticky protocol-error flags.
module csi2_raw10_unpacker #(
  parameter logic [5:0] RAW10_DT = 6'h2B,
  parameter logic [5:0] FS_DT    = 6'h00,
  parameter logic [5:0] FE_DT    = 6'h01
) (
  input  logic        mipi_byte_clock,
  input  logic        mipi_byte_reset_n,
  input  logic        enable_in,
  input  logic        sp_en_in,
  input  logic        lp_av_en_in,
  input  logic        payload_en_in,
  input  logic [7:0]  payload_in,
  input  logic [5:0]  dt_in,
  input  logic [15:0] wc_in,
  input  logic        error_clear_in,
  output logic [9:0]  pixel_data_out,
  output logic        pixel_valid_out,
  output logic        line_valid_out,
  output logic        frame_valid_out,
  output logic [12:0] line_pixel_count_out,
  output logic [11:0] frame_line_count_out,
  output logic [3:0]  error_flags_out
);

  typedef enum logic [1:0] {StIdle, StFrame, StLine, StDrain} state_e;

  state_e          state_q, state_d;
  logic [15:0]     wc_q, wc_d, byte_cnt_q, byte_cnt_d;
  logic [2:0]      slot_q, slot_d;
  logic [3:0][7:0] bytes_q, bytes_d;
  logic [39:0]     grp_q, grp_d;
  logic            emit_q, emit_d;
  logic [1:0]      idx_q, idx_d;
  logic            line_valid_q, line_valid_d;
  logic [12:0]     line_pix_q, line_pix_d;
  logic [12:0]     line_pixel_count_q, line_pixel_count_d;
  logic [11:0]     line_cnt_q, line_cnt_d;
  logic [11:0]     frame_line_count_q, frame_line_count_d;
  logic            fe_pend_q, fe_pend_d;
  logic [3:0]      err_q, err_d, err_set;
  logic            payload_en_q;

  logic        fs, fe, lp_ok, last_pix, payload_end, finish_line;
  logic [11:0] line_cnt_inc;

  assign fs    = sp_en_in && (dt_in == FS_DT) && enable_in;
  assign fe    = sp_en_in && (dt_in == FE_DT);
  assign lp_ok = lp_av_en_in && (dt_in == RAW10_DT);
  assign line_cnt_inc = (line_cnt_q == 12'hFFF) ? line_cnt_q : line_cnt_q + 12'd1;

  always_comb begin
    state_d            = state_q;
    wc_d               = wc_q;
    byte_cnt_d         = byte_cnt_q;
    slot_d             = slot_q;
    bytes_d            = bytes_q;
    grp_d              = grp_q;
    emit_d             = emit_q;
    idx_d              = idx_q;
    line_valid_d       = line_valid_q;
    line_pix_d         = line_pix_q;
    line_pixel_count_d = line_pixel_count_q;
    line_cnt_d         = line_cnt_q;
    frame_line_count_d = frame_line_count_q;
    fe_pend_d          = fe_pend_q;
    err_set            = '0;
    payload_end        = 1'b0;
    finish_line        = 1'b0;
    last_pix           = emit_q && (idx_q == 2'd3);

    if (emit_q) begin
      idx_d = idx_q + 2'd1;
      if (last_pix) emit_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (lp_ok) err_set[2] = 1'b1;
        if (fs) begin
          state_d    = StFrame;
          line_cnt_d = '0;
        end
      end
      StFrame: begin
        if (fe) begin
          state_d            = StIdle;
          frame_line_count_d = line_cnt_q;
        end else if (lp_ok) begin
          state_d    = StLine;
          wc_d       = wc_in;
          byte_cnt_d = '0;
          slot_d     = '0;
          line_pix_d = '0;
          if ((wc_in % 16'd5) != 16'd0) err_set[0] = 1'b1;
        end
      end
      StLine: begin
        if (fe) fe_pend_d = 1'b1;
        if (payload_en_in && (byte_cnt_q < wc_q)) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (slot_q == 3'd4) begin
            // Fifth byte completes a group; p0 is presented on the next cycle.
            grp_d        = {payload_in, bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};
            emit_d       = 1'b1;
            idx_d        = 2'd0;
            slot_d       = '0;
            line_valid_d = 1'b1;
            line_pix_d   = (line_pix_q > 13'd8187) ? 13'h1FFF : line_pix_q + 13'd4;
          end else begin
            bytes_d[slot_q[1:0]] = payload_in;
            slot_d               = slot_q + 3'd1;
          end
          if (byte_cnt_q + 16'd1 == wc_q) payload_end = 1'b1;
        end else if (byte_cnt_q >= wc_q) begin
          payload_end = 1'b1;
        end else if (payload_en_q && !payload_en_in) begin
          err_set[1]  = 1'b1;
          payload_end = 1'b1;
        end
        if (payload_end) begin
          slot_d = '0;
          if (emit_d) state_d = StDrain;
          else        finish_line = 1'b1;
        end
      end
      StDrain: begin
        if (fe) fe_pend_d = 1'b1;
        if (last_pix) finish_line = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (finish_line) begin
      line_valid_d       = 1'b0;
      line_pixel_count_d = line_pix_d;
      line_cnt_d         = line_cnt_inc;
      if (fe_pend_d) begin
        state_d            = StIdle;
        frame_line_count_d = line_cnt_inc;
        fe_pend_d          = 1'b0;
      end else begin
        state_d = StFrame;
      end
    end

    // A second FS restarts the frame and drops any line in flight.
    if (fs && (state_q != StIdle)) begin
      err_set[3]         = 1'b1;
      state_d            = StFrame;
      line_cnt_d         = '0;
      emit_d             = 1'b0;
      line_valid_d       = 1'b0;
      fe_pend_d          = 1'b0;
      slot_d             = '0;
      line_pixel_count_d = line_pixel_count_q;
      frame_line_count_d = frame_line_count_q;
    end

    if (!enable_in) begin
      state_d            = StIdle;
      emit_d             = 1'b0;
      line_valid_d       = 1'b0;
      fe_pend_d          = 1'b0;
      slot_d             = '0;
      line_cnt_d         = line_cnt_q;
      line_pixel_count_d = line_pixel_count_q;
      frame_line_count_d = frame_line_count_q;
    end

    err_d = (err_q & ~{4{error_clear_in}}) | err_set;
  end

  always_ff @(posedge mipi_byte_clock or negedge mipi_byte_reset_n) begin
    if (!mipi_byte_reset_n) begin
      state_q            <= StIdle;
      wc_q               <= '0;
      byte_cnt_q         <= '0;
      slot_q             <= '0;
      bytes_q            <= '0;
      grp_q              <= '0;
      emit_q             <= 1'b0;
      idx_q              <= '0;
      line_valid_q       <= 1'b0;
      line_pix_q         <= '0;
      line_pixel_count_q <= '0;
      line_cnt_q         <= '0;
      frame_line_count_q <= '0;
      fe_pend_q          <= 1'b0;
      err_q              <= '0;
      payload_en_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      wc_q               <= wc_d;
      byte_cnt_q         <= byte_cnt_d;
      slot_q             <= slot_d;
      bytes_q            <= bytes_d;
      grp_q              <= grp_d;
      emit_q             <= emit_d;
      idx_q              <= idx_d;
      line_valid_q       <= line_valid_d;
      line_pix_q         <= line_pix_d;
      line_pixel_count_q <= line_pixel_count_d;
      line_cnt_q         <= line_cnt_d;
      frame_line_count_q <= frame_line_count_d;
      fe_pend_q          <= fe_pend_d;
      err_q              <= err_d;
      payload_en_q       <= payload_en_in;
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd0: pixel_data_out = {grp_q[7:0],   grp_q[33:32]};
      2'd1: pixel_data_out = {grp_q[15:8],  grp_q[35:34]};
      2'd2: pixel_data_out = {grp_q[23:16], grp_q[37:36]};
      2'd3: pixel_data_out = {grp_q[31:24], grp_q[39:38]};
      default: pixel_data_out = '0;
    endcase
  end

  assign pixel_valid_out      = emit_q;
  assign line_valid_out       = line_valid_q;
  assign frame_valid_out      = (state_q != StIdle);
  assign line_pixel_count_out = line_pixel_count_q;
  assign frame_line_count_out = frame_line_count_q;
  assign error_flags_out      = err_q;

endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// Directed bench for csi2_raw10_unpacker: one task per scenario, inline checks against
// hand-computed RAW10 pixels, counts and error flags.
module tb_csi2_raw10_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic        sp_en = 1'b0, lp_en = 1'b0, pay_en = 1'b0, err_clr = 1'b0;
  logic [7:0]  pay = '0;
  logic [5:0]  dt = '0;
  logic [15:0] wc = '0;
  logic [9:0]  pix;
  logic        pv, lv, fv;
  logic [12:0] lpc;
  logic [11:0] flc;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  logic [9:0] got[$];
  int run = 0, gap1 = 0, gapbad = 0;

  localparam logic [5:0] FS = 6'h00, FE = 6'h01;

  csi2_raw10_unpacker dut (
    .mipi_byte_clock      (clk),
    .mipi_byte_reset_n    (rst_n),
    .enable_in            (enable),
    .sp_en_in             (sp_en),
    .lp_av_en_in          (lp_en),
    .payload_en_in        (pay_en),
    .payload_in           (pay),
    .dt_in                (dt),
    .wc_in                (wc),
    .error_clear_in       (err_clr),
    .pixel_data_out       (pix),
    .pixel_valid_out      (pv),
    .line_valid_out       (lv),
    .frame_valid_out      (fv),
    .line_pixel_count_out (lpc),
    .frame_line_count_out (flc),
    .error_flags_out      (flags)
  );

  always #5 clk = ~clk;

  // Pixel capture and gap measurement inside a line.
  always @(negedge clk) begin
    if (pv) got.push_back(pix);
    if (lv && !pv) run <= run + 1;
    else           run <= 0;
    if (lv && pv && run == 1) gap1 <= gap1 + 1;
    if (lv && pv && run > 1)  gapbad <= gapbad + 1;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sp(input logic [5:0] t);
    sp_en = 1'b1; dt = t;
    cyc();
    sp_en = 1'b0; dt = '0;
  endtask

  task automatic send_lp(input int n);
    lp_en = 1'b1; dt = 6'h2B; wc = n[15:0];
    cyc();
    lp_en = 1'b0; dt = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pay_en = 1'b1; pay = b;
    cyc();
    pay_en = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  function automatic logic [7:0] bv(input int line, input int i);
    return 8'(i * 7 + line);
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({pv, lv, fv} !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got %b expected 000", {pv, lv, fv});
    end
    checks++;
    if (pix !== 10'd0) begin errors++; $display("FAIL reset_pixel: got %h expected 000", pix); end
    checks++;
    if ({lpc, flc, flags} !== 29'd0) begin
      errors++; $display("FAIL reset_counts: lpc %0d flc %0d flags %b expected 0", lpc, flc, flags);
    end
    @(negedge clk) rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    logic [7:0] b[5];
    logic [9:0] e[4];
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hE4};
    e = '{10'h048, 10'h0D1, 10'h15A, 10'h1E3};
    send_sp(FS);
    checks++;
    if (fv !== 1'b1) begin errors++; $display("FAIL basic_fv: got %b expected 1", fv); end
    send_lp(5);
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({pv, pix} !== {1'b1, e[k]}) begin
        errors++; $display("FAIL basic_p%0d: got v=%b %h expected v=1 %h", k, pv, pix, e[k]);
      end
      cyc();
    end
    checks++;
    if ({pv, lv} !== 2'b00) begin errors++; $display("FAIL basic_lv_fall: got %b expected 00", {pv, lv}); end
    checks++;
    if (lpc !== 13'd4) begin errors++; $display("FAIL basic_lpc: got %0d expected 4", lpc); end
    send_sp(FE);
    checks++;
    if ({fv, flc, flags} !== {1'b0, 12'd1, 4'd0}) begin
      errors++; $display("FAIL basic_fe: fv %b flc %0d flags %b expected 0 1 0000", fv, flc, flags);
    end
  endtask

  task automatic test_back_to_back();
    send_sp(FS);
    for (int line = 0; line < 720; line++) begin
      int n, base, g1, gb, mism;
      n = (line < 3) ? 900 : 10;
      base = got.size(); g1 = gap1; gb = gapbad;
      send_lp(n);
      for (int i = 0; i < n; i++) send_byte(bv(line, i));
      cyc(6);
      if (line < 3) begin
        mism = 0;
        if (got.size() - base != 720) mism = 1000;
        else begin
          for (int g = 0; g < 180; g++) begin
            logic [7:0] b4;
            b4 = bv(line, 5 * g + 4);
            for (int k = 0; k < 4; k++)
              if (got[base + 4 * g + k] !== {bv(line, 5 * g + k), b4[2 * k +: 2]}) mism++;
          end
        end
        checks++;
        if (mism != 0) begin errors++; $display("FAIL b2b_pixels line %0d: %0d bad expected 0", line, mism); end
        checks++;
        if (lpc !== 13'd720) begin errors++; $display("FAIL b2b_lpc line %0d: got %0d expected 720", line, lpc); end
        checks++;
        if ((gap1 - g1) != 179 || gapbad != gb) begin
          errors++;
          $display("FAIL b2b_gaps line %0d: got %0d one-cycle gaps, %0d long expected 179, 0",
                   line, gap1 - g1, gapbad - gb);
        end
      end
    end
    send_sp(FE);
    checks++;
    if (flc !== 12'd720) begin errors++; $display("FAIL b2b_flc: got %0d expected 720", flc); end
    checks++;
    if ({lpc, flags} !== {13'd8, 4'd0}) begin
      errors++; $display("FAIL b2b_tail: lpc %0d flags %b expected 8 0000", lpc, flags);
    end
  endtask

  task automatic test_wc_mod();
    logic [9:0] e[8];
    int base, mism;
    e = '{10'h005, 10'h009, 10'h00C, 10'h010, 10'h01A, 10'h01E, 10'h020, 10'h024};
    send_sp(FS);
    base = got.size();
    send_lp(12);
    for (int i = 1; i <= 12; i++) send_byte(8'(i));
    cyc(6);
    mism = 0;
    if (got.size() - base != 8) mism = 100;
    else for (int k = 0; k < 8; k++) if (got[base + k] !== e[k]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL wcmod_pixels: %0d bad (count %0d) expected 0", mism, got.size() - base); end
    checks++;
    if (flags !== 4'b0001) begin errors++; $display("FAIL wcmod_flag0: got %b expected 0001", flags); end
    checks++;
    if (lpc !== 13'd8) begin errors++; $display("FAIL wcmod_lpc: got %0d expected 8", lpc); end
    pulse_clear();
    checks++;
    if (flags !== 4'b0000) begin errors++; $display("FAIL wcmod_clear: got %b expected 0000", flags); end
    send_sp(FE);
  endtask

  task automatic test_saturation();
    send_sp(FS);
    repeat (4100) begin
      send_lp(0);
      cyc();
    end
    send_sp(FE);
    checks++;
    if (flc !== 12'd4095) begin errors++; $display("FAIL sat_flc: got %0d expected 4095", flc); end
    checks++;
    if ({lpc, flags} !== 17'd0) begin errors++; $display("FAIL sat_tail: lpc %0d flags %b expected 0 0000", lpc, flags); end
  endtask

  task automatic test_short_payload();
    logic [7:0] b[7];
    logic [9:0] e[4];
    int base, mism;
    b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hFF, 8'h11, 8'h22};
    e = '{10'h283, 10'h287, 10'h28B, 10'h28F};
    send_sp(FS);
    base = got.size();
    send_lp(10);
    for (int i = 0; i < 7; i++) send_byte(b[i]);
    cyc(6);
    mism = 0;
    if (got.size() - base != 4) mism = 100;
    else for (int k = 0; k < 4; k++) if (got[base + k] !== e[k]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL short_pixels: %0d bad (count %0d) expected 0", mism, got.size() - base); end
    checks++;
    if ({lpc, flags} !== {13'd4, 4'b0010}) begin
      errors++; $display("FAIL short_flag1: lpc %0d flags %b expected 4 0010", lpc, flags);
    end
    pulse_clear();
    checks++;
    if (flags !== 4'b0000) begin errors++; $display("FAIL short_clear: got %b expected 0000", flags); end
    send_sp(FE);
    checks++;
    if (flc !== 12'd1) begin errors++; $display("FAIL short_flc: got %0d expected 1", flc); end
  endtask

  task automatic test_errors();
    logic [7:0] b[5];
    int base;
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hE4};
    base = got.size();
    err_clr = 1'b1;
    send_lp(5);
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    cyc(6);
    checks++;
    if (got.size() != base || fv !== 1'b0) begin
      errors++; $display("FAIL idle_lp_pixels: got %0d pixels fv %b expected 0 0", got.size() - base, fv);
    end
    checks++;
    if (flags !== 4'b0100) begin errors++; $display("FAIL idle_lp_flag2: got %b expected 0100", flags); end
    pulse_clear();
    send_sp(FS);
    send_lp(10);
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    checks++;
    if ({pv, lv} !== 2'b11) begin errors++; $display("FAIL refs_line_on: got %b expected 11", {pv, lv}); end
    pay_en = 1'b1; pay = 8'h99; sp_en = 1'b1; dt = FS;
    cyc();
    pay_en = 1'b0; sp_en = 1'b0; dt = '0;
    checks++;
    if ({pv, lv, fv} !== 3'b001) begin
      errors++; $display("FAIL refs_abort: got pv/lv/fv %b expected 001", {pv, lv, fv});
    end
    cyc();
    checks++;
    if (flags !== 4'b1000) begin errors++; $display("FAIL refs_flag3: got %b expected 1000", flags); end
    send_sp(FE);
    checks++;
    if (flc !== 12'd0) begin errors++; $display("FAIL refs_flc: got %0d expected 0", flc); end
    pulse_clear();
  endtask

  task automatic test_enable_reset();
    logic [7:0] b[5];
    logic [9:0] e[4];
    int base, mism;
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hE4};
    e = '{10'h048, 10'h0D1, 10'h15A, 10'h1E3};
    send_sp(FS);
    send_lp(10);
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    enable = 1'b0;
    cyc();
    checks++;
    if ({pv, lv, fv} !== 3'b000) begin errors++; $display("FAIL enable_off: got %b expected 000", {pv, lv, fv}); end
    checks++;
    if (lpc !== 13'd4) begin errors++; $display("FAIL enable_hold: lpc %0d expected 4", lpc); end
    enable = 1'b1;
    cyc(3);
    send_sp(FS);
    send_lp(10);
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pv, lv, fv, pix} !== 13'd0) begin
      errors++; $display("FAIL reset_midline: pv/lv/fv %b pix %h expected 000 000", {pv, lv, fv}, pix);
    end
    checks++;
    if ({lpc, flc} !== 25'd0) begin errors++; $display("FAIL reset_counts2: lpc %0d flc %0d expected 0 0", lpc, flc); end
    @(negedge clk) rst_n = 1'b1;
    cyc(2);
    base = got.size();
    send_sp(FS);
    send_lp(5);
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    cyc(6);
    mism = 0;
    if (got.size() - base != 4) mism = 100;
    else for (int k = 0; k < 4; k++) if (got[base + k] !== e[k]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL recover_pixels: %0d bad (count %0d) expected 0", mism, got.size() - base); end
    send_sp(FE);
    checks++;
    if ({lpc, flc, flags} !== {13'd4, 12'd1, 4'd0}) begin
      errors++; $display("FAIL recover_counts: lpc %0d flc %0d flags %b expected 4 1 0000", lpc, flc, flags);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wc_mod();
    test_saturation();
    test_short_payload();
    test_errors();
    test_enable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csi2_raw10_unpacker.md
Name: csi2_raw10_unpacker

Overview:
- Replaces the vendor byte-to-pixel stage on the camera path.
- Consumes the registered CSI-2 receiver outputs in the MIPI byte clock domain: payload bytes, short and long packet enables, data type and word count.
- Unpacks RAW10 long packets (4 pixels per 5 bytes) into 10-bit pixels with line and frame framing.
- Produces per-line and per-frame counts and sticky protocol-error flags. The pixel-clock CDC FIFO that follows it is a separate block.

Parameters:
- RAW10_DT, 6'h2B, long-packet data type accepted as video.
- FS_DT, 6'h00, frame-start short-packet data type.
- FE_DT, 6'h01, frame-end short-packet data type.

Ports:
- mipi_byte_clock  input  1  byte clock.
- mipi_byte_reset_n  input  1  reset, asynchronous, active-low.
- enable_in  input  1  block enable (low = power save / abort).
- sp_en_in  input  1  one-cycle pulse: short packet header valid.
- lp_av_en_in  input  1  one-cycle pulse: long packet header valid with dt_in == RAW10_DT.
- payload_en_in  input  1  payload_in valid this cycle.
- payload_in  input  8  payload byte.
- dt_in  input  6  packet data type, valid with sp_en_in / lp_av_en_in.
- wc_in  input  16  long-packet word count in bytes, valid with lp_av_en_in.
- error_clear_in  input  1  pulse, clears error_flags_out.
- pixel_data_out  output  10  unpacked pixel.
- pixel_valid_out  output  1  pixel_data_out valid.
- line_valid_out  output  1  high from first pixel of a line through its last pixel.
- frame_valid_out  output  1  frame active.
- line_pixel_count_out  output  13  pixels in last completed line, saturating.
- frame_line_count_out  output  12  lines in last completed frame, saturating.
- error_flags_out  output  4  sticky: [0] wc%5≠0, [1] short payload, [2] long packet outside frame, [3] FS inside frame.

Behaviour:
- Reset (asynchronous): every output and internal register goes to 0, state goes to IDLE. Reset mid-line drops the line with no further pixels.
- States:
  - IDLE: frame_valid_out=0.
  - FRAME: frame active, waiting for a line.
  - LINE: collecting payload.
  - DRAIN: emitting the last group after the payload ends.
- IDLE→FRAME on sp_en_in && dt_in==FS_DT && enable_in. frame_valid_out rises the next cycle and the internal line counter clears.
- FRAME→LINE on lp_av_en_in. wc_in is latched and the byte counter and group index clear. If wc_in%5≠0, set flag[0]; trailing wc_in%5 bytes are discarded.
- LINE: each payload_en_in cycle stores payload_in into group slot 0..4.
  - On slot 4, the 5 bytes are latched into an output group register.
  - Pixels are emitted on the next 4 cycles, one per cycle, pixel_valid_out=1.
  - Unpacking: p0={b0,b4[1:0]}, p1={b1,b4[3:2]}, p2={b2,b4[5:4]}, p3={b3,b4[7:6]}.
  - Latency is 1 cycle from the 5th byte to p0. The next group's 5th byte cannot arrive before p3 is emitted, so no overflow is possible.
  - pixel_valid_out gaps between groups are legal.
- End of line:
  - A line ends when the byte counter reaches wc or payload_en_in falls. If payload_en_in falls before wc bytes, set flag[1] and discard the partial group.
  - LINE→DRAIN while a latched group is still emitting; DRAIN→FRAME after p3.
  - line_valid_out falls the cycle after the last pixel.
  - line_pixel_count_out updates on that cycle. The internal line counter increments, saturating at 4095.
- Frame end: sp_en_in && dt_in==FE_DT.
  - In FRAME: go to IDLE next cycle.
  - In LINE or DRAIN: the line completes normally (the payload has already ended), then go to IDLE.
  - frame_line_count_out updates when frame_valid_out falls.
- lp_av_en_in in IDLE: set flag[2]; the payload is ignored with no pixels emitted.
- FS while frame_valid_out=1: set flag[3], restart the frame, and clear the line counter. Any line in progress is aborted and line_valid_out falls next cycle.
- Unknown short-packet data types are ignored.
- enable_in low: any state goes to IDLE next cycle; pixel_valid_out, line_valid_out and frame_valid_out go to 0; counts hold.
- error_flags_out: each bit sets on its event. error_clear_in clears all bits. A set and a clear in the same cycle leaves the set bit at 1.
- Counts saturate and never wrap.

Test Plan:
- FS; long packet wc=5, bytes 12,34,56,78,E4; FE.
  - Expect pixels 0x048, 0x0D1, 0x15A, 0x1E3 on 4 consecutive cycles starting 1 cycle after byte E4.
  - Expect line_pixel_count_out=4, frame_line_count_out=1, error_flags_out=0.
- FS; 720 lines of wc=900 with back-to-back payload; FE.
  - Expect 720 pixels per line, frame_line_count_out=720, 1 cycle between pixel groups, no errors.
- Long packet wc=12.
  - Expect 8 pixels, flag[0]=1, last 2 bytes dropped.
- Long packet wc=10 with payload_en_in falling after 7 bytes.
  - Expect 4 pixels, flag[1]=1, line_pixel_count_out=4, then error_clear_in → flags 0.
- Long packet before any FS → no pixel_valid_out, flag[2]=1. FS, then second FS mid-line → flag[3]=1, line_valid_out low next cycle, frame_valid_out stays 1.
- Deassert enable_in mid-group, then assert mipi_byte_reset_n=0 mid-line.
  - Expect all valid outputs 0 the following cycle and immediately on reset respectively.
  - Expect the next FS after recovery to frame correctly.
